// File: rtl/req_ack_pkg.sv
// Shared types and constants for the request/acknowledge responder.
package req_ack_pkg;

  localparam int unsigned PEND_W      = 4;
  localparam int unsigned LATENCY_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_e;

  // Responder state implied by a given pending-ack count.
  function automatic state_e state_of(input logic [PEND_W-1:0] cnt,
                                      input logic [PEND_W-1:0] max_cnt);
    if (cnt == '0)
      return IDLE;
    else if (cnt == max_cnt)
      return FULL;
    else
      return BUSY;
  endfunction

endpackage

// File: rtl/req_delay_line.sv
// Fixed-depth request delay line; depth 0 is a reset-gated pass-through.
module req_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_pass
    // A request presented during reset never becomes eligible.
    assign q_o = d_i & ~rst_i;
  end else begin : g_shift
    logic [DEPTH-1:0] shift_q;

    // Shift sampled requests one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        shift_q <= '0;
      end else begin
        shift_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          shift_q[i] <= shift_q[i-1];
        end
      end
    end

    assign q_o = shift_q[DEPTH-1];
  end

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: delays each request, then acks it or
// queues it in a saturating pending counter drained while hold is low.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              hold,
  output logic              ack,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [1:0]        state,
  output logic              overflow
);

  localparam int unsigned       DEPTH   = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] ONE     = PEND_W'(1);

  logic              arr;
  logic              ack_c;
  logic [PEND_W-1:0] pend_q, pend_d;
  state_e            state_q, state_d;
  logic              overflow_q, overflow_d;

  req_delay_line #(
    .DEPTH (DEPTH)
  ) u_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (req),
    .q_o   (arr)
  );

  // Ack/backlog decision: drain the backlog first, otherwise ack the arrival directly.
  always_comb begin
    ack_c      = ~rst & ~hold & ((pend_q != '0) | arr);
    pend_d     = pend_q;
    overflow_d = overflow_q;
    if (ack_c) begin
      // Arrival alongside a backlog ack replaces the acked entry: count unchanged.
      if ((pend_q != '0) && !arr) begin
        pend_d = pend_q - ONE;
      end
    end else if (arr) begin
      if (pend_q == MAX_CNT) begin
        overflow_d = 1'b1;
      end else begin
        pend_d = pend_q + ONE;
      end
    end
    state_d = state_of(pend_d, MAX_CNT);
  end

  // Responder FSM with registered count, state and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign ack      = ack_c;
  assign pend_cnt = pend_q;
  assign state    = state_q;
  assign overflow = overflow_q;

  a_no_ack_on_hold: assert property (@(posedge clk) ack |-> !hold);
  a_pend_bounded:   assert property (@(posedge clk) pend_q <= MAX_CNT);

  if (LATENCY == 0) begin : g_lat0_assert
    a_direct_ack: assert property (@(posedge clk) disable iff (rst)
                                   (req && !hold && pend_q == '0) |-> ack);
  end

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: five instances with different LATENCY/MAX_PEND,
// a request-timeline model checked every cycle, plus literal scenario pins.
module tb_req_ack_responder;

  localparam int NI = 5;

  logic              clk;
  logic [NI-1:0]     req, hold, rst, ack, ovf;
  logic [3:0]        pend [NI];
  logic [1:0]        st   [NI];

  int checks = 0;
  int failures = 0;

  function automatic int lat_of(input int i);
    return (i == 4) ? 1 : i;
  endfunction

  function automatic int mp_of(input int i);
    return (i == 4) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    req_ack_responder #(
      .LATENCY  ((g == 4) ? 1 : g),
      .MAX_PEND ((g == 4) ? 1 : 4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req      (req[g]),
      .hold     (hold[g]),
      .ack      (ack[g]),
      .pend_cnt (pend[g]),
      .state    (st[g]),
      .overflow (ovf[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: requests are tracked on a timeline of eligibility cycles.
  int cyc = 0;
  int pend_m   [NI];
  bit ovf_m    [NI];
  bit due      [NI][8];
  int acc      [NI];
  int drop     [NI];
  int flush    [NI];
  int dut_acks [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      pend_m[i] = 0; ovf_m[i] = 0; acc[i] = 0; drop[i] = 0; flush[i] = 0; dut_acks[i] = 0;
      for (int j = 0; j < 8; j++) due[i][j] = 0;
    end
  end

  // Compare process: runs mid-low-phase after inputs settle, then advances the model.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < NI; i++) begin
      int L, exp_st;
      bit arr, exp_ack;
      L = lat_of(i);
      if (L == 0) begin
        arr = req[i] && !rst[i];
      end else begin
        arr = due[i][cyc % 8];
        due[i][cyc % 8] = 0;
      end
      exp_ack = !rst[i] && !hold[i] && (pend_m[i] > 0 || arr);
      exp_st  = (pend_m[i] == 0) ? 0 : ((pend_m[i] == mp_of(i)) ? 2 : 1);
      chk($sformatf("ack[%0d]", i), int'(ack[i]), int'(exp_ack));
      chk($sformatf("pend[%0d]", i), int'(pend[i]), pend_m[i]);
      chk($sformatf("state[%0d]", i), int'(st[i]), exp_st);
      chk($sformatf("overflow[%0d]", i), int'(ovf[i]), int'(ovf_m[i]));
      if (ack[i] === 1'b1) dut_acks[i]++;
      if (rst[i]) begin
        flush[i] += pend_m[i] + int'(arr);
        for (int j = 0; j < 8; j++) begin
          flush[i] += int'(due[i][j]);
          due[i][j] = 0;
        end
        pend_m[i] = 0;
        ovf_m[i]  = 0;
      end else begin
        if (req[i]) begin
          acc[i]++;
          if (L > 0) due[i][(cyc + L) % 8] = 1;
        end
        if (exp_ack) begin
          if (pend_m[i] > 0 && !arr) pend_m[i]--;
        end else if (arr) begin
          if (pend_m[i] < mp_of(i)) pend_m[i]++;
          else begin
            ovf_m[i] = 1;
            drop[i]++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic step(input logic [NI-1:0] r, input logic [NI-1:0] h, input logic [NI-1:0] x);
    @(negedge clk);
    req  = r;
    hold = h;
    rst  = x;
    #3;
  endtask

  initial begin
    logic [NI-1:0] r, h, x;
    int exp_p [8];
    req = '0; hold = '0; rst = '1;
    exp_p = '{0, 0, 1, 2, 3, 4, 4, 4};

    step('0, '0, '1);
    step('0, '0, '1);
    step('0, '0, '0);
    for (int i = 0; i < NI; i++) begin
      chk("rst_pend", int'(pend[i]), 0);
      chk("rst_state", int'(st[i]), 0);
      chk("rst_ovf", int'(ovf[i]), 0);
      chk("rst_ack", int'(ack[i]), 0);
    end

    // LATENCY=0: same-cycle ack for a two-cycle request
    for (int k = 0; k < 2; k++) begin
      step(5'b00001, '0, '0);
      chk("l0_ack", int'(ack[0]), 1);
      chk("l0_pend", int'(pend[0]), 0);
      chk("l0_state", int'(st[0]), 0);
    end
    step('0, '0, '0);
    chk("l0_ack_off", int'(ack[0]), 0);

    // LATENCY=2: single request acked exactly two cycles later
    step(5'b00100, '0, '0);
    chk("l2_ack_c0", int'(ack[2]), 0);
    step('0, '0, '0);
    chk("l2_ack_c1", int'(ack[2]), 0);
    step('0, '0, '0);
    chk("l2_ack_c2", int'(ack[2]), 1);
    step('0, '0, '0);
    chk("l2_ack_c3", int'(ack[2]), 0);

    // LATENCY=1, MAX_PEND=4: six requests under hold saturate and overflow
    for (int k = 0; k < 8; k++) begin
      step((k < 6) ? 5'b00010 : 5'b00000, 5'b00010, '0);
      chk("fill_pend", int'(pend[1]), exp_p[k]);
    end
    chk("fill_state", int'(st[1]), 2);
    chk("fill_ovf", int'(ovf[1]), 1);
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0);
      chk("drain_ack", int'(ack[1]), 1);
      chk("drain_pend", int'(pend[1]), 4 - k);
    end
    step('0, '0, '0);
    chk("drain_ack_end", int'(ack[1]), 0);
    chk("drain_pend_end", int'(pend[1]), 0);
    chk("drain_state_end", int'(st[1]), 0);
    chk("drain_ovf_sticky", int'(ovf[1]), 1);

    // LATENCY=1: backlog of 2 with a request every cycle stays at 2
    repeat (3) step(5'b00010, 5'b00010, '0);
    for (int k = 0; k < 5; k++) begin
      step(5'b00010, '0, '0);
      chk("steady_ack", int'(ack[1]), 1);
      chk("steady_pend", int'(pend[1]), 2);
    end
    repeat (5) step('0, '0, '0);

    // LATENCY=3: reset flushes two in-flight requests
    step(5'b01000, '0, '0);
    step(5'b01000, '0, '0);
    step('0, '0, 5'b01000);
    step('0, '0, '0);
    chk("flush_ack_c4", int'(ack[3]), 0);
    chk("flush_pend", int'(pend[3]), 0);
    chk("flush_state", int'(st[3]), 0);
    chk("flush_ovf", int'(ovf[3]), 0);
    step('0, '0, '0);
    chk("flush_ack_c5", int'(ack[3]), 0);
    step('0, '0, '0);
    chk("flush_ack_c6", int'(ack[3]), 0);

    // MAX_PEND=1: IDLE jumps straight to FULL and back
    step(5'b10000, 5'b10000, '0);
    step('0, 5'b10000, '0);
    step('0, 5'b10000, '0);
    chk("mp1_pend", int'(pend[4]), 1);
    chk("mp1_full", int'(st[4]), 2);
    step('0, '0, '0);
    chk("mp1_ack", int'(ack[4]), 1);
    step('0, '0, '0);
    chk("mp1_idle", int'(st[4]), 0);
    chk("mp1_pend0", int'(pend[4]), 0);

    // Random traffic with occasional resets, then drain
    step('0, '0, '1);
    repeat (1000) begin
      for (int i = 0; i < NI; i++) begin
        r[i] = 1'($urandom_range(0, 1));
        h[i] = ($urandom_range(0, 9) < 3);
        x[i] = ($urandom_range(0, 99) < 2);
      end
      step(r, h, x);
    end
    repeat (12) step('0, '0, '0);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ack_total[%0d]", i), dut_acks[i], acc[i] - drop[i] - flush[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
- REQ-001 Parameter LATENCY, default 1: cycles from a sampled req to that request's ack becoming eligible; legal range 0..7.
- REQ-002 Parameter MAX_PEND, default 4: capacity of the pending-ack counter; legal range 1..15.
- REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
- REQ-004 Port rst, input, 1: synchronous, active-high reset.
- REQ-005 Port req, input, 1: request strobe, sampled on posedge clk.
- REQ-006 Port hold, input, 1: consumer back-pressure; while high, ack SHALL be 0.
- REQ-007 Port ack, output, 1: acknowledge; one cycle high per delivered request.
- REQ-008 Port pend_cnt, output, 4: count of eligible, not yet acknowledged requests.
- REQ-009 Port state, output, 2: responder FSM state, encoded IDLE=0, BUSY=1, FULL=2.
- REQ-010 Port overflow, output, 1: sticky flag; set when a request is dropped.

Function
- REQ-011 With LATENCY=0, ack SHALL equal req & ~hold & ~rst in the same cycle (overlapped: req |-> ack), when pend_cnt==0.
- REQ-012 With LATENCY=0 and pend_cnt>0, the backlog SHALL drain first, and a new req SHALL be counted, not acked immediately.
- REQ-013 With LATENCY=N>=1, each sampled req SHALL enter an N-stage delay line and become eligible exactly N cycles later; with hold=0 and an empty backlog, the design SHALL guarantee req |-> ##N ack.
- REQ-014 An eligible request SHALL be acked in its eligibility cycle if hold=0 and pend_cnt==0; otherwise it SHALL increment pend_cnt.
- REQ-015 When pend_cnt>0 and hold=0, ack SHALL be 1 and pend_cnt SHALL decrement by 1 per cycle.
- REQ-016 A simultaneous eligible arrival and ack SHALL leave pend_cnt unchanged.
- REQ-017 An arrival with pend_cnt==MAX_PEND and no ack in that cycle SHALL be dropped, set overflow, and leave pend_cnt unchanged; pend_cnt SHALL never exceed MAX_PEND or wrap.
- REQ-018 pend_cnt SHALL never decrement below 0.
- REQ-019 ack SHALL never be high in a cycle where hold is high.
- REQ-020 ack SHALL never be high without a corresponding prior or current eligible request, so that no spurious acks occur.
- REQ-021 FSM: IDLE when pend_cnt==0; BUSY when 0<pend_cnt<MAX_PEND; FULL when pend_cnt==MAX_PEND.
- REQ-022 The FSM state SHALL be registered and derived from the next-cycle pend_cnt, giving transitions IDLE->BUSY, BUSY->FULL, FULL->BUSY and BUSY->IDLE; a direct IDLE<->FULL jump SHALL be possible only when MAX_PEND==1.
- REQ-023 overflow SHALL clear only on rst.

Reset
- REQ-024 While rst is high at posedge clk, the design SHALL clear the delay line, clear pend_cnt to 0, set state to IDLE, and clear overflow to 0.
- REQ-025 ack SHALL be 0 in the cycle after a reset edge.
- REQ-026 With LATENCY=0, ack SHALL be forced to 0 combinationally while rst is high.
- REQ-027 Reset in mid-operation SHALL discard all in-flight and pending requests, with no ack for them after reset.
- REQ-028 A req sampled in the same cycle as rst SHALL be ignored.

Structure
- REQ-029 A shared package req_ack_pkg SHALL hold the state enum typedef (IDLE/BUSY/FULL), the PEND_W=4 constant and the LATENCY_MAX=7 constant.
- REQ-030 The N-stage delay line SHALL be a separate sub-module req_delay_line, parameterised by depth; depth 0 SHALL be pass-through.
- REQ-031 The design SHALL carry embedded concurrent assertions:
  - ack |-> !hold;
  - pend_cnt <= MAX_PEND;
  - for LATENCY=0 with an empty backlog: req && !hold |-> ack.

Verification
- REQ-032 LATENCY=0, hold=0, req high at 12 ns to 22 ns -> ack high in the same cycles, pend_cnt stays 0, state stays IDLE.
- REQ-033 LATENCY=2, single req at cycle 3 -> ack exactly at cycle 5 only, and the assertion req |-> ##2 ack passes.
- REQ-034 LATENCY=1, MAX_PEND=4, hold=1, 6 consecutive reqs -> pend_cnt 1,2,3,4,4,4, state reaches FULL, overflow=1; then hold=0 -> 4 consecutive acks, pend_cnt returns to 0, state returns to IDLE, overflow stays 1.
- REQ-035 LATENCY=1, pend_cnt=2, hold=0, req each cycle -> ack continuous and pend_cnt constant at 2 (simultaneous increment and decrement).
- REQ-036 LATENCY=3, reqs at cycles 1 and 2, rst at cycle 3 -> no ack at cycles 4 or 5, pend_cnt=0, state=IDLE, overflow=0.
- REQ-037 Random req/hold for 1000 cycles -> total acks equal accepted reqs minus drops minus flushed, and no assertion failures.
